// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of requester A/B handshakes and the RAM-side bus for ram_arbiter
interface ram_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_wdata, a_rdata;
  logic                     b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_wdata, b_rdata;
  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn, ram_dataOut;
  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut
  );
  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between requesters A and B with optional lock; RAM_ARB_RR_EN selects round-robin contention instead of fixed A priority
module ram_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, OWN_A, OWN_B} owner_t;
  owner_t                   r_owner;
  logic                     r_a_rvalid, r_b_rvalid;
  logic                     w_a_gnt, w_b_gnt, w_a_wins, w_we;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    w_wdata;
`ifdef RAM_ARB_RR_EN
  logic                     r_last_b;
  assign w_a_wins = r_last_b;
`else
  assign w_a_wins = 1'b1;
`endif
  // grant decision: owner has exclusive access, otherwise the contention rule picks
  always_comb begin
    w_a_gnt = reset_n && bus.a_req && (r_owner == OWN_A || (r_owner == NONE && (!bus.b_req || w_a_wins)));
    w_b_gnt = reset_n && bus.b_req && (r_owner == OWN_B || (r_owner == NONE && !w_a_gnt));
    w_we    = w_a_gnt ? bus.a_we    : w_b_gnt && bus.b_we;
    w_addr  = w_a_gnt ? bus.a_addr  : w_b_gnt ? bus.b_addr  : '0;
    w_wdata = w_a_gnt ? bus.a_wdata : w_b_gnt ? bus.b_wdata : '0;
  end
  assign bus.a_gnt      = w_a_gnt;
  assign bus.b_gnt      = w_b_gnt;
  assign bus.ram_wEn    = w_we;
  assign bus.ram_addr   = w_addr;
  assign bus.ram_dataIn = w_wdata;
  assign bus.a_rvalid   = r_a_rvalid;
  assign bus.b_rvalid   = r_b_rvalid;
  assign bus.a_rdata    = bus.ram_dataOut;
  assign bus.b_rdata    = bus.ram_dataOut;
  // ownership FSM, read-response tagging and last-grant pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= NONE;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
`ifdef RAM_ARB_RR_EN
      r_last_b   <= 1'b1;
`endif
    end else begin
      r_a_rvalid <= w_a_gnt && !bus.a_we;
      r_b_rvalid <= w_b_gnt && !bus.b_we;
      if (w_a_gnt && bus.a_lock) r_owner <= OWN_A;
      else if (w_b_gnt && bus.b_lock) r_owner <= OWN_B;
      else if ((r_owner == OWN_A && !bus.a_lock) || (r_owner == OWN_B && !bus.b_lock)) r_owner <= NONE;
`ifdef RAM_ARB_RR_EN
      if (w_a_gnt) r_last_b <= 1'b0;
      else if (w_b_gnt) r_last_b <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed test-plan scenarios plus randomized traffic against a transaction-level model of the arbiter and RAM
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_dataIn;
    else bus.ram_dataOut <= ram[bus.ram_addr];
  end
  int n_chk = 0;
  int n_err = 0;
  int m_owner = 0;
  bit m_last_b = 1'b1;
  bit e_rv_a = 0, e_rv_b = 0, e_kn_a = 0, e_kn_b = 0;
  logic [DW-1:0] e_d_a, e_d_b;
  logic [DW-1:0] m_mem [int];
  bit last_ga, last_gb;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_a_gnt"}, bus.a_gnt, 0);
    chk({tag, "_b_gnt"}, bus.b_gnt, 0);
    chk({tag, "_a_rvalid"}, bus.a_rvalid, 0);
    chk({tag, "_b_rvalid"}, bus.b_rvalid, 0);
    chk({tag, "_wen"}, bus.ram_wEn, 0);
    chk({tag, "_addr"}, bus.ram_addr, 0);
    chk({tag, "_din"}, bus.ram_dataIn, 0);
  endtask
  task automatic model_reset();
    m_owner = 0; m_last_b = 1'b1; e_rv_a = 0; e_rv_b = 0;
  endtask
  // one clock cycle: inputs already driven at negedge; check, advance model, move to next negedge
  task automatic cyc();
    bit ga, gb;
    #1;
    chk("a_rvalid", bus.a_rvalid, e_rv_a);
    chk("b_rvalid", bus.b_rvalid, e_rv_b);
    if (e_rv_a && e_kn_a) chk("a_rdata", bus.a_rdata, e_d_a);
    if (e_rv_b && e_kn_b) chk("b_rdata", bus.b_rdata, e_d_b);
    if (m_owner == 1) begin ga = bus.a_req; gb = 0; end
    else if (m_owner == 2) begin ga = 0; gb = bus.b_req; end
    else if (bus.a_req && bus.b_req) begin ga = RR ? m_last_b : 1'b1; gb = !ga; end
    else begin ga = bus.a_req; gb = bus.b_req; end
    chk("a_gnt", bus.a_gnt, ga);
    chk("b_gnt", bus.b_gnt, gb);
    chk("ram_wEn", bus.ram_wEn, ga ? bus.a_we : gb ? bus.b_we : 0);
    chk("ram_addr", bus.ram_addr, ga ? bus.a_addr : gb ? bus.b_addr : 0);
    chk("ram_dataIn", bus.ram_dataIn, ga ? bus.a_wdata : gb ? bus.b_wdata : 0);
    e_rv_a = ga && !bus.a_we;
    e_rv_b = gb && !bus.b_we;
    e_kn_a = m_mem.exists(int'(bus.a_addr));
    e_kn_b = m_mem.exists(int'(bus.b_addr));
    if (e_kn_a) e_d_a = m_mem[int'(bus.a_addr)];
    if (e_kn_b) e_d_b = m_mem[int'(bus.b_addr)];
    if (ga && bus.a_we) m_mem[int'(bus.a_addr)] = bus.a_wdata;
    if (gb && bus.b_we) m_mem[int'(bus.b_addr)] = bus.b_wdata;
    if (ga) m_last_b = 1'b0;
    if (gb) m_last_b = 1'b1;
    if (ga && bus.a_lock) m_owner = 1;
    else if (gb && bus.b_lock) m_owner = 2;
    else if ((m_owner == 1 && !bus.a_lock) || (m_owner == 2 && !bus.b_lock)) m_owner = 0;
    last_ga = ga;
    last_gb = gb;
    @(negedge clk);
  endtask
  initial begin
    int na, nb;
    bus.a_req = 0; bus.a_we = 0; bus.a_lock = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = '0; bus.b_wdata = '0;
    @(negedge clk);
    #1 chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    // write then back-to-back read on A
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 12'h010; bus.a_wdata = 32'hDEADBEEF;
    cyc();
    bus.a_we = 0;
    cyc();
    bus.a_req = 0;
    #1;
    chk("single_a_rvalid", bus.a_rvalid, 1);
    chk("single_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    chk("single_b_rvalid", bus.b_rvalid, 0);
    cyc();
    // contention: both read for four cycles
    na = 0; nb = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 12'h010;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 12'h020;
    for (int i = 0; i < 4; i++) begin
      cyc();
      na += int'(last_ga); nb += int'(last_gb);
    end
    chk("contention_a", na, RR ? 2 : 4);
    chk("contention_b", nb, RR ? 2 : 0);
    bus.a_req = 0; bus.b_req = 0;
    cyc();
    // B locked write burst while A keeps requesting
    na = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 12'(12'h100 + i); bus.b_wdata = $urandom; bus.b_lock = (i < 3);
      bus.a_req = (i > 0); bus.a_we = 0; bus.a_addr = 12'h010;
      cyc();
      na += int'(last_ga); nb += int'(last_gb);
    end
    chk("lock_a_blocked", na, 0);
    chk("lock_b_beats", nb, 4);
    bus.b_req = 0; bus.b_lock = 0;
    cyc();
    chk("lock_release_a", last_ga, 1);
    bus.a_req = 0;
    cyc();
    // pipelined alternating reads, each port's address known
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 12'h001; bus.a_wdata = 32'h11111111; cyc();
    bus.a_addr = 12'h003; bus.a_wdata = 32'h33333333; cyc();
    bus.a_req = 0; bus.b_req = 1; bus.b_we = 1; bus.b_addr = 12'h002; bus.b_wdata = 32'h22222222; cyc();
    bus.b_we = 0; bus.b_req = 0; bus.a_req = 1; bus.a_we = 0; bus.a_addr = 12'h001; cyc();
    bus.a_req = 0; bus.b_req = 1; bus.b_addr = 12'h002;
    #1 chk("alt_a_rdata", bus.a_rdata, 32'h11111111);
    cyc();
    bus.b_req = 0; bus.a_req = 1; bus.a_addr = 12'h003;
    #1 chk("alt_b_rdata", bus.b_rdata, 32'h22222222);
    cyc();
    bus.a_req = 0;
    #1 chk("alt_a3_rdata", bus.a_rdata, 32'h33333333);
    cyc();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!bus.a_req || last_ga) begin
        bus.a_req = ($urandom_range(0, 9) < 6); bus.a_we = 1'($urandom_range(0, 1));
        bus.a_addr = 12'($urandom_range(0, 15)); bus.a_wdata = $urandom;
        bus.a_lock = bus.a_req && ($urandom_range(0, 3) == 0);
      end
      if (!bus.b_req || last_gb) begin
        bus.b_req = ($urandom_range(0, 9) < 6); bus.b_we = 1'($urandom_range(0, 1));
        bus.b_addr = 12'($urandom_range(0, 15)); bus.b_wdata = $urandom;
        bus.b_lock = bus.b_req && ($urandom_range(0, 3) == 0);
      end
      cyc();
    end
    bus.a_req = 0; bus.b_req = 0; bus.a_lock = 0; bus.b_lock = 0;
    cyc();
    cyc();
    // reset asserted during a locked read grant
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 12'h010; bus.a_lock = 1;
    #1 chk("mid_a_gnt", bus.a_gnt, 1);
    #1 reset_n = 1'b0;
    #1 chk_idle("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    bus.a_req = 0; bus.a_lock = 0;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 12'h010; bus.b_lock = 0;
    #1;
    chk("post_reset_a_rvalid", bus.a_rvalid, 0);
    chk("post_reset_b_gnt", bus.b_gnt, 1);
    cyc();
    bus.b_req = 0;
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
